autocorr_peak_picker: RTL and testbench
=======================================

Name: autocorr_peak_picker

Overview:
- Sits downstream of the signed 12x12 multiply-accumulate correlation datapath.
- Consumes one 36-bit signed correlation sum per lag, in lag order 0..MAX_LAG, over a valid/ready handshake.
- Reports the lag with the largest correlation inside [MIN_LAG, MAX_LAG] as the pitch period in samples.
- Flags the frame voiced or unvoiced by comparing that peak against the lag-0 energy.

Parameters:
- SUM_W, 36: width of the signed correlation sums.
- LAG_W, 10: width of the lag counter and of out_lag.
- MIN_LAG, 20: smallest lag eligible as a peak.
- MAX_LAG, 400: last lag of a frame; must satisfy MIN_LAG <= MAX_LAG < 2^LAG_W.
- VOICE_SHIFT, 2: frame is voiced when peak > (r0 >>> VOICE_SHIFT).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a new frame; honoured only in IDLE
- in_valid  in  1  in_sum is valid
- in_ready  out  1  block accepts in_sum this cycle
- in_sum  in  SUM_W  signed correlation sum for the current lag
- busy  out  1  high in COLLECT and DONE
- out_valid  out  1  one-cycle pulse, frame result ready
- out_lag  out  LAG_W  best lag; 0 when no positive peak
- out_peak  out  SUM_W  signed sum at out_lag; 0 when no positive peak
- voiced  out  1  voicing decision for the frame

Behaviour:
- Reset: state=IDLE. in_ready=0, busy=0, out_valid=0, out_lag=0, out_peak=0, voiced=0. Internal lag counter, r0, best_sum and best_lag are all cleared.
- States: IDLE -> COLLECT on start. COLLECT -> DONE on the handshake that carries lag==MAX_LAG. DONE -> IDLE after exactly 1 cycle.
- IDLE entry on start (next cycle):
  - lag=0, r0=0.
  - best_sum=0, best_lag=0.
  - out_lag, out_peak and voiced keep the previous frame's values until DONE.
- in_ready = (state==COLLECT). A transfer occurs when in_valid && in_ready. in_valid low stalls the frame indefinitely with no state change.
- Per transfer, with current lag L:
  - L==0: r0 <= in_sum.
  - MIN_LAG <= L <= MAX_LAG and in_sum > best_sum (signed, strict): best_sum <= in_sum, best_lag <= L.
  - 1 <= L < MIN_LAG: sum is consumed and discarded.
  - lag <= L+1, except on L==MAX_LAG, where the FSM goes to DONE and lag is not incremented.
- Ties: the first (smallest) lag wins. Because best_sum starts at 0, only strictly positive sums can win. If none does, best_lag stays 0.
- DONE cycle (registered, 1-cycle latency after the last transfer):
  - out_valid=1 for exactly this cycle.
  - out_lag=best_lag, out_peak=best_sum.
  - voiced = (best_lag!=0) && (best_sum > (r0 >>> VOICE_SHIFT)), evaluated as a signed comparison at SUM_W bits.
  - in_ready=0.
- The comparison uses the final best_sum, including an update made by the lag==MAX_LAG transfer. Implement this by comparing in the DONE cycle, or by forwarding that update.
- start while busy is ignored; it is not queued.
- start asserted in the same cycle as the DONE->IDLE transition is ignored. start is sampled only when the state is IDLE.
- rst mid-frame: returns to IDLE immediately and clears all outputs. No out_valid is produced for the aborted frame.
- Arithmetic: no saturation is needed; all comparisons are signed at SUM_W bits. r0 >>> VOICE_SHIFT is an arithmetic shift. A negative r0 (a malformed stream) gives a negative threshold, and the block still follows the formula.
- Lag counter never exceeds MAX_LAG; no wrap-around is possible.

Test Plan:
- Reset, then stream with MIN_LAG=20, MAX_LAG=400, VOICE_SHIFT=2:
  - r0=1000, all other lags 0 except lag 100 = 600.
  - Required: out_valid pulse 1 cycle after the lag-400 transfer, out_lag=100, out_peak=600, voiced=1.
- Same frame but lag 100 = 200 -> out_lag=100, out_peak=200, voiced=0 (200 <= 250).
- Lags 20..400 all negative, lag 5 = 5000 -> out_lag=0, out_peak=0, voiced=0. This checks that sub-MIN_LAG lags are ignored.
- Ties: lag 50 = 300 and lag 150 = 300 -> out_lag=50. Peak 900 placed only at lag 400 with r0=1000 -> out_lag=400, out_peak=900, voiced=1.
- Random in_valid gaps (about 50% duty) over the first-scenario data:
  - Required: identical result.
  - in_ready=1 throughout COLLECT.
  - Exactly 401 transfers counted.
  - Pulsing start mid-frame has no effect.
- Assert rst after lag 200, then start a new frame:
  - Required: no out_valid for the aborted frame.
  - Outputs read 0 after reset.
  - New frame's result is independent of the aborted data.

Source files
------------

// File: rtl/autocorr_peak_picker_if.sv
// Handshake and result bundle for autocorr_peak_picker.
//   start                 frame start request (honoured only while idle)
//   in_valid/in_ready     per-lag correlation sum handshake, in_sum carries the sum
//   busy                  block is collecting or reporting a frame
//   out_valid             one-cycle pulse with out_lag / out_peak / voiced
// slave  : the peak picker's view
// master : the producer / consumer driving it
interface autocorr_peak_picker_if #(
    parameter int unsigned SUM_W = 36,
    parameter int unsigned LAG_W = 10
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] in_sum;
    logic             busy;
    logic             out_valid;
    logic [LAG_W-1:0] out_lag;
    logic [SUM_W-1:0] out_peak;
    logic             voiced;

    modport slave (
        input  start,
        input  in_valid,
        output in_ready,
        input  in_sum,
        output busy,
        output out_valid,
        output out_lag,
        output out_peak,
        output voiced
    );

    modport master (
        output start,
        output in_valid,
        input  in_ready,
        output in_sum,
        input  busy,
        input  out_valid,
        input  out_lag,
        input  out_peak,
        input  voiced
    );
endinterface

// File: rtl/autocorr_peak_picker.sv
// Autocorrelation peak picker.
// Consumes one signed correlation sum per lag (lag 0..MAX_LAG) and reports the
// lag with the largest strictly positive sum in [MIN_LAG, MAX_LAG], plus a
// voiced flag when that peak exceeds r0 >>> VOICE_SHIFT.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  autocorr_peak_picker_if.slave (start, in_* handshake, busy, out_* result)
module autocorr_peak_picker #(
    parameter int unsigned SUM_W       = 36,
    parameter int unsigned LAG_W       = 10,
    parameter int unsigned MIN_LAG     = 20,
    parameter int unsigned MAX_LAG     = 400,
    parameter int unsigned VOICE_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    autocorr_peak_picker_if.slave bus
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    localparam logic [LAG_W-1:0] MinLagL = LAG_W'(MIN_LAG);
    localparam logic [LAG_W-1:0] MaxLagL = LAG_W'(MAX_LAG);

    logic [1:0]              state_q, state_d;
    logic [LAG_W-1:0]        lag_q, lag_d;
    logic signed [SUM_W-1:0] r0_q, r0_d;
    logic signed [SUM_W-1:0] best_sum_q, best_sum_d;
    logic [LAG_W-1:0]        best_lag_q, best_lag_d;
    logic                    out_valid_q, out_valid_d;
    logic [LAG_W-1:0]        out_lag_q, out_lag_d;
    logic signed [SUM_W-1:0] out_peak_q, out_peak_d;
    logic                    voiced_q, voiced_d;

    logic signed [SUM_W-1:0] sum_in;
    logic signed [SUM_W-1:0] threshold;
    logic                    xfer;

    assign sum_in = $signed(bus.in_sum);
    assign xfer   = bus.in_valid && (state_q == StCollect);

    always_comb begin
        state_d     = state_q;
        lag_d       = lag_q;
        r0_d        = r0_q;
        best_sum_d  = best_sum_q;
        best_lag_d  = best_lag_q;
        out_valid_d = 1'b0;
        out_lag_d   = out_lag_q;
        out_peak_d  = out_peak_q;
        voiced_d    = voiced_q;
        threshold   = '0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StCollect;
                    lag_d      = '0;
                    r0_d       = '0;
                    best_sum_d = '0;
                    best_lag_d = '0;
                end
            end
            StCollect: begin
                if (xfer) begin
                    if (lag_q == '0) begin
                        r0_d = sum_in;
                    end
                    // best_sum starts at 0, so only strictly positive sums win;
                    // strict compare keeps the earliest lag on ties.
                    if ((lag_q >= MinLagL) && (sum_in > best_sum_q)) begin
                        best_sum_d = sum_in;
                        best_lag_d = lag_q;
                    end
                    if (lag_q == MaxLagL) begin
                        // Forward the final-transfer update so the result
                        // registers hold the complete frame in the DONE cycle.
                        state_d     = StDone;
                        threshold   = r0_d >>> VOICE_SHIFT;
                        out_valid_d = 1'b1;
                        out_lag_d   = best_lag_d;
                        out_peak_d  = best_sum_d;
                        voiced_d    = (best_lag_d != '0) && (best_sum_d > threshold);
                    end else begin
                        lag_d = lag_q + LAG_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lag_q       <= '0;
            r0_q        <= '0;
            best_sum_q  <= '0;
            best_lag_q  <= '0;
            out_valid_q <= 1'b0;
            out_lag_q   <= '0;
            out_peak_q  <= '0;
            voiced_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lag_q       <= lag_d;
            r0_q        <= r0_d;
            best_sum_q  <= best_sum_d;
            best_lag_q  <= best_lag_d;
            out_valid_q <= out_valid_d;
            out_lag_q   <= out_lag_d;
            out_peak_q  <= out_peak_d;
            voiced_q    <= voiced_d;
        end
    end

    assign bus.in_ready  = (state_q == StCollect);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.out_lag   = out_lag_q;
    assign bus.out_peak  = out_peak_q;
    assign bus.voiced    = voiced_q;

endmodule

// File: tb/tb_autocorr_peak_picker.sv
module tb_autocorr_peak_picker;

    localparam int SUM_W = 36;
    localparam int LAG_W = 10;
    localparam int MAXL  = 400;

    typedef struct packed {
        logic [LAG_W-1:0] lag;
        logic [SUM_W-1:0] peak;
        logic             voiced;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;

    exp_t sb_q[$];
    logic signed [SUM_W-1:0] frame_mem [0:MAXL];

    autocorr_peak_picker_if #(.SUM_W(SUM_W), .LAG_W(LAG_W)) bus ();

    autocorr_peak_picker #(
        .SUM_W      (SUM_W),
        .LAG_W      (LAG_W),
        .MIN_LAG    (20),
        .MAX_LAG    (MAXL),
        .VOICE_SHIFT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    // Transfers happen at the clock edge; inputs are stable there.
    always @(posedge clk) begin
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) xfer_cnt++;
    end

    // Scoreboard: every out_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_lag", 64'(bus.out_lag), 64'(e.lag));
                check("out_peak", 64'(bus.out_peak), 64'(e.peak));
                check("voiced", 64'(bus.voiced), 64'(e.voiced));
            end
        end
    end

    task automatic fill(input logic signed [SUM_W-1:0] v);
        for (int l = 0; l <= MAXL; l++) frame_mem[l] = v;
    endtask

    task automatic push_exp(input int lag, input logic signed [SUM_W-1:0] peak, input bit v);
        exp_t e;
        e.lag    = LAG_W'(lag);
        e.peak   = peak;
        e.voiced = v;
        sb_q.push_back(e);
    endtask

    // Entered and left at a negedge. last_lag < MAXL streams a partial frame.
    task automatic run_frame(input bit gaps, input int last_lag, input bit pulse_start);
        int c0;
        c0 = xfer_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'd1);
        for (int l = 0; l <= last_lag; l++) begin
            bit sent;
            int tries;
            sent  = 1'b0;
            tries = 0;
            while (!sent && tries < 64) begin
                check("in_ready_collect", 64'(bus.in_ready), 64'd1);
                if (gaps && $urandom_range(1, 0) == 1) begin
                    bus.in_valid = 1'b0;
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_sum   = frame_mem[l];
                    sent         = 1'b1;
                end
                bus.start = (pulse_start && l >= 150 && l < 153);
                tries++;
                @(negedge clk);
            end
            if (!sent) check("xfer_timeout", 64'd0, 64'd1);
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        check("xfer_count", 64'(xfer_cnt - c0), 64'(last_lag + 1));
        if (last_lag == MAXL) begin
            check("out_valid_latency", 64'(bus.out_valid), 64'd1);
            @(negedge clk);
            check("out_valid_one_cycle", 64'(bus.out_valid), 64'd0);
            check("busy_after_done", 64'(bus.busy), 64'd0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_lag"}, 64'(bus.out_lag), 64'd0);
        check({tag, "_out_peak"}, 64'(bus.out_peak), 64'd0);
        check({tag, "_voiced"}, 64'(bus.voiced), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sum   = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("reset");

        // Voiced peak at lag 100
        fill(0); frame_mem[0] = 1000; frame_mem[100] = 600;
        push_exp(100, 600, 1'b1);
        run_frame(1'b0, MAXL, 1'b0);
        check("hold_out_lag", 64'(bus.out_lag), 64'd100);

        // Same frame, peak below r0/4 -> unvoiced
        frame_mem[100] = 200;
        push_exp(100, 200, 1'b0);
        run_frame(1'b0, MAXL, 1'b0);

        // Only sub-MIN_LAG lag is positive
        fill(0); frame_mem[0] = 1000;
        for (int l = 20; l <= MAXL; l++) frame_mem[l] = -(l + 1);
        frame_mem[5] = 5000;
        push_exp(0, 0, 1'b0);
        run_frame(1'b0, MAXL, 1'b0);

        // Tie: earliest lag wins
        fill(0); frame_mem[0] = 1000; frame_mem[50] = 300; frame_mem[150] = 300;
        push_exp(50, 300, 1'b1);
        run_frame(1'b0, MAXL, 1'b0);

        // Peak only on the last lag
        fill(0); frame_mem[0] = 1000; frame_mem[400] = 900;
        push_exp(400, 900, 1'b1);
        run_frame(1'b0, MAXL, 1'b0);

        // Peak exactly at threshold is not voiced
        fill(0); frame_mem[0] = 1000; frame_mem[399] = 250;
        push_exp(399, 250, 1'b0);
        run_frame(1'b0, MAXL, 1'b0);

        // Negative r0 gives negative threshold
        fill(0); frame_mem[0] = -1000; frame_mem[30] = 1;
        push_exp(30, 1, 1'b1);
        run_frame(1'b0, MAXL, 1'b0);

        // First scenario with random in_valid gaps and a mid-frame start pulse
        fill(0); frame_mem[0] = 1000; frame_mem[100] = 600;
        push_exp(100, 600, 1'b1);
        run_frame(1'b1, MAXL, 1'b1);

        // Abort after lag 200, then an independent frame
        fill(0); frame_mem[0] = 1000; frame_mem[100] = 600;
        run_frame(1'b0, 200, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero_outputs("abort");
        repeat (5) @(negedge clk);
        check("abort_no_out_valid", 64'(bus.out_valid), 64'd0);
        fill(0); frame_mem[0] = 1000; frame_mem[400] = 900;
        push_exp(400, 900, 1'b1);
        run_frame(1'b0, MAXL, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
